// File: rtl/ssram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ssram_arbiter
// Description : Two-port (A: cartridge bus, B: loader/DMA) request arbiter in
//               front of the ssram serial-SRAM controller. Serialises one
//               access at a time, steers read data back to the issuing port
//               and forces completion of reads that never return data.
// Revision    : 1.0 - initial release
// ============================================================================
module ssram_arbiter #(
  parameter int FIXED_PRIORITY = 0,
  parameter int READ_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  // port A
  input  logic [18:0] a_address,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic        a_write,
  input  logic [7:0]  a_wdata,
  output logic [7:0]  a_rdata,
  output logic        a_rdata_en,
  // port B
  input  logic [18:0] b_address,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic        b_write,
  input  logic [7:0]  b_wdata,
  output logic [7:0]  b_rdata,
  output logic        b_rdata_en,
  // ssram controller side
  output logic [18:0] ssram_address,
  output logic        ssram_valid,
  input  logic        ssram_ready,
  output logic        ssram_write,
  output logic [7:0]  ssram_wdata,
  input  logic [7:0]  ssram_rdata,
  input  logic        ssram_rdata_en,
  output logic        timeout_error
);

  localparam logic [1:0]  ST_IDLE      = 2'd0;
  localparam logic [1:0]  ST_ISSUE     = 2'd1;
  localparam logic [1:0]  ST_WAIT_RD   = 2'd2;
  localparam logic        PORT_A       = 1'b0;
  localparam logic        PORT_B       = 1'b1;
  localparam logic [15:0] TIMEOUT_LAST = 16'(READ_TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [18:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        valid_q, valid_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  a_rdata_q, a_rdata_d;
  logic [7:0]  b_rdata_q, b_rdata_d;

  logic        w_sel;
  logic        w_accept;
  logic        w_rd_timeout;
  logic        w_rd_done;
  logic [7:0]  w_rd_value;

  // Arbitration: pick the port that would be granted if the arbiter is idle.
  always_comb begin
    w_sel = PORT_A;
    if (a_valid && b_valid) begin
      if (FIXED_PRIORITY != 0) begin
        w_sel = PORT_A;
      end else begin
        w_sel = ~last_grant_q;
      end
    end else if (b_valid) begin
      w_sel = PORT_B;
    end
    w_accept = (state_q == ST_IDLE) && (a_valid || b_valid);
  end

  // Read completion: real data takes precedence over the watchdog.
  always_comb begin
    w_rd_timeout = (state_q == ST_WAIT_RD) && !ssram_rdata_en && (cnt_q == TIMEOUT_LAST);
    w_rd_done    = ((state_q == ST_WAIT_RD) && ssram_rdata_en) || w_rd_timeout;
    w_rd_value   = ssram_rdata_en ? ssram_rdata : 8'hFF;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one outstanding access at a time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (ssram_ready) state_d = write_q ? ST_IDLE : ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (w_rd_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: request latch, watchdog counter, held read data.
  always_comb begin
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    valid_d      = valid_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          addr_d       = (w_sel == PORT_B) ? b_address : a_address;
          wdata_d      = (w_sel == PORT_B) ? b_wdata   : a_wdata;
          write_d      = (w_sel == PORT_B) ? b_write   : a_write;
          valid_d      = 1'b1;
          owner_d      = w_sel;
          last_grant_d = w_sel;
        end
      end
      ST_ISSUE: begin
        if (ssram_ready) begin
          valid_d = 1'b0;
          cnt_d   = 16'd0;
        end
      end
      ST_WAIT_RD: begin
        cnt_d = cnt_q + 16'd1;
        if (w_rd_done) begin
          if (owner_q == PORT_B) begin
            b_rdata_d = w_rd_value;
          end else begin
            a_rdata_d = w_rd_value;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; last_grant resets to B so A wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= 19'd0;
      wdata_q      <= 8'd0;
      write_q      <= 1'b0;
      valid_q      <= 1'b0;
      owner_q      <= PORT_A;
      last_grant_q <= PORT_B;
      cnt_q        <= 16'd0;
      a_rdata_q    <= 8'd0;
      b_rdata_q    <= 8'd0;
    end else begin
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      valid_q      <= valid_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  // Outputs: ready and read-return strobes are combinational, same cycle.
  always_comb begin
    a_ready       = (state_q == ST_IDLE) && a_valid && (w_sel == PORT_A);
    b_ready       = (state_q == ST_IDLE) && b_valid && (w_sel == PORT_B);
    a_rdata_en    = w_rd_done && (owner_q == PORT_A);
    b_rdata_en    = w_rd_done && (owner_q == PORT_B);
    a_rdata       = a_rdata_en ? w_rd_value : a_rdata_q;
    b_rdata       = b_rdata_en ? w_rd_value : b_rdata_q;
    timeout_error = w_rd_timeout;
    ssram_address = addr_q;
    ssram_wdata   = wdata_q;
    ssram_write   = write_q;
    ssram_valid   = valid_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ssram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssram_arbiter
// Description : Self-checking bench for ssram_arbiter: reset values, an
//               arbitration vector table, directed multi-cycle sequences and
//               a randomized run against a transaction-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssram_arbiter;

  localparam int TB_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [18:0] a_address, b_address;
  logic        a_valid, b_valid, a_write, b_write;
  logic [7:0]  a_wdata, b_wdata;
  logic        a_ready, b_ready, a_rdata_en, b_rdata_en;
  logic [7:0]  a_rdata, b_rdata;
  logic [18:0] ssram_address;
  logic        ssram_valid, ssram_ready, ssram_write, ssram_rdata_en;
  logic [7:0]  ssram_wdata, ssram_rdata;
  logic        timeout_error;

  // second instance, fixed priority, write-only traffic
  logic        f_a_valid, f_b_valid, f_ssram_ready, f_ssram_rdata_en;
  logic        f_a_ready, f_b_ready, f_a_rdata_en, f_b_rdata_en;
  logic [7:0]  f_a_rdata, f_b_rdata, f_ssram_wdata;
  logic [18:0] f_ssram_address;
  logic        f_ssram_valid, f_ssram_write, f_timeout_error;

  always #5 clk = ~clk;

  ssram_arbiter #(.FIXED_PRIORITY(0), .READ_TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_address(a_address), .a_valid(a_valid), .a_ready(a_ready), .a_write(a_write),
    .a_wdata(a_wdata), .a_rdata(a_rdata), .a_rdata_en(a_rdata_en),
    .b_address(b_address), .b_valid(b_valid), .b_ready(b_ready), .b_write(b_write),
    .b_wdata(b_wdata), .b_rdata(b_rdata), .b_rdata_en(b_rdata_en),
    .ssram_address(ssram_address), .ssram_valid(ssram_valid), .ssram_ready(ssram_ready),
    .ssram_write(ssram_write), .ssram_wdata(ssram_wdata), .ssram_rdata(ssram_rdata),
    .ssram_rdata_en(ssram_rdata_en), .timeout_error(timeout_error)
  );

  ssram_arbiter #(.FIXED_PRIORITY(1), .READ_TIMEOUT(TB_TIMEOUT)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .a_address(a_address), .a_valid(f_a_valid), .a_ready(f_a_ready), .a_write(1'b1),
    .a_wdata(a_wdata), .a_rdata(f_a_rdata), .a_rdata_en(f_a_rdata_en),
    .b_address(b_address), .b_valid(f_b_valid), .b_ready(f_b_ready), .b_write(1'b1),
    .b_wdata(b_wdata), .b_rdata(f_b_rdata), .b_rdata_en(f_b_rdata_en),
    .ssram_address(f_ssram_address), .ssram_valid(f_ssram_valid), .ssram_ready(f_ssram_ready),
    .ssram_write(f_ssram_write), .ssram_wdata(f_ssram_wdata), .ssram_rdata(ssram_rdata),
    .ssram_rdata_en(f_ssram_rdata_en), .timeout_error(f_timeout_error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_write = 1'b0; b_write = 1'b0;
    a_address = 19'd0; b_address = 19'd0; a_wdata = 8'd0; b_wdata = 8'd0;
    ssram_ready = 1'b0; ssram_rdata_en = 1'b0; ssram_rdata = 8'd0;
    f_a_valid = 1'b0; f_b_valid = 1'b0; f_ssram_ready = 1'b1; f_ssram_rdata_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // arbitration vectors applied combinationally in IDLE right after reset
  typedef struct {
    logic av;
    logic bv;
    logic ea;
    logic eb;
  } vec_t;
  vec_t tbl [4];

  // reference-model state (transaction level)
  int          ph;        // 0 no access, 1 request presented to ssram, 2 awaiting read data
  int          w, resp, lat, idx, ng, nf, first_f;
  int          g [3];
  int          gf [3];
  logic        m_owner, m_last, m_wr;
  logic [18:0] m_addr;
  logic [7:0]  m_wd, resp_data, a_last, b_last, e_val;
  logic        a_taken, b_taken, g_any, g_b, e_a_en, e_b_en, e_err;
  logic [7:0]  mem [int];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0};   // first tie goes to A

    // ---------------- reset values ----------------
    reset_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_write = 1'b0; b_write = 1'b0;
    a_address = 19'd0; b_address = 19'd0; a_wdata = 8'd0; b_wdata = 8'd0;
    ssram_ready = 1'b0; ssram_rdata_en = 1'b0; ssram_rdata = 8'd0;
    f_a_valid = 1'b0; f_b_valid = 1'b0; f_ssram_ready = 1'b1; f_ssram_rdata_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ssram_valid", 32'(ssram_valid), 32'd0);
    chk("rst_ssram_write", 32'(ssram_write), 32'd0);
    chk("rst_ssram_address", 32'(ssram_address), 32'd0);
    chk("rst_ssram_wdata", 32'(ssram_wdata), 32'd0);
    chk("rst_ready", 32'({a_ready, b_ready}), 32'd0);
    chk("rst_rdata_en", 32'({a_rdata_en, b_rdata_en}), 32'd0);
    chk("rst_timeout_error", 32'(timeout_error), 32'd0);
    reset_n = 1'b1;

    // ---------------- arbitration table (within one half-cycle) ----------------
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      a_valid = tbl[i].av;
      b_valid = tbl[i].bv;
      #1;
      chk($sformatf("tbl%0d_a_ready", i), 32'(a_ready), 32'(tbl[i].ea));
      chk($sformatf("tbl%0d_b_ready", i), 32'(b_ready), 32'(tbl[i].eb));
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // ---------------- repeated ties: round-robin vs fixed priority ----------------
    @(negedge clk);
    a_valid = 1'b1; b_valid = 1'b1; a_write = 1'b1; b_write = 1'b1;
    a_address = 19'h00010; b_address = 19'h00020; a_wdata = 8'h11; b_wdata = 8'h22;
    ssram_ready = 1'b1; f_a_valid = 1'b1; f_b_valid = 1'b1;
    ng = 0; nf = 0;
    for (int i = 0; i < 3; i++) begin g[i] = 9; gf[i] = 9; end
    for (int i = 0; i < 20 && (ng < 3 || nf < 3); i++) begin
      #1;
      if (ng < 3 && (a_ready || b_ready)) begin g[ng] = b_ready ? 1 : 0; ng++; end
      if (nf < 3 && (f_a_ready || f_b_ready)) begin gf[nf] = f_b_ready ? 1 : 0; nf++; end
      @(negedge clk);
    end
    chk("rr_grant0", 32'(g[0]), 32'd0);
    chk("rr_grant1", 32'(g[1]), 32'd1);
    chk("rr_grant2", 32'(g[2]), 32'd0);
    chk("fp_grant0", 32'(gf[0]), 32'd0);
    chk("fp_grant1", 32'(gf[1]), 32'd0);
    chk("fp_grant2", 32'(gf[2]), 32'd0);
    a_valid = 1'b0; b_valid = 1'b0; f_a_valid = 1'b0;
    first_f = 9;
    for (int i = 0; i < 10 && first_f == 9; i++) begin
      #1;
      if (f_a_ready || f_b_ready) first_f = f_b_ready ? 1 : 0;
      @(negedge clk);
    end
    chk("fp_b_after_a_drops", 32'(first_f), 32'd1);
    f_b_valid = 1'b0;

    // ---------------- read timeout ----------------
    do_reset();
    @(negedge clk);
    a_valid = 1'b1; a_write = 1'b0; a_address = 19'h00777; ssram_ready = 1'b1;
    #1;
    chk("to_a_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    chk("to_issue_valid", 32'(ssram_valid), 32'd1);
    chk("to_issue_addr", 32'(ssram_address), 32'h00777);
    chk("to_issue_write", 32'(ssram_write), 32'd0);
    idx = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (a_rdata_en) begin idx = i; break; end
    end
    chk("to_cycle", 32'(idx), 32'(TB_TIMEOUT - 1));
    chk("to_rdata", 32'(a_rdata), 32'hFF);
    chk("to_error", 32'(timeout_error), 32'd1);
    chk("to_b_rdata_en", 32'(b_rdata_en), 32'd0);
    @(negedge clk);
    #1;
    chk("to_error_one_cycle", 32'(timeout_error), 32'd0);
    chk("to_rdata_held", 32'(a_rdata), 32'hFF);

    // ---------------- A read outstanding, B waiting; then B read ----------------
    @(negedge clk);
    a_valid = 1'b1; a_write = 1'b0; a_address = 19'h00123;
    #1;
    chk("ab_a_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b1; b_write = 1'b0; b_address = 19'h12345;
    #1;
    chk("ab_b_blocked_issue", 32'(b_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("ab_b_blocked_wait", 32'(b_ready), 32'd0);
    @(negedge clk);
    ssram_rdata_en = 1'b1; ssram_rdata = 8'h5C;
    #1;
    chk("ab_a_rdata_en", 32'(a_rdata_en), 32'd1);
    chk("ab_a_rdata", 32'(a_rdata), 32'h5C);
    chk("ab_b_blocked_strobe", 32'(b_ready), 32'd0);
    chk("ab_b_rdata_en_quiet", 32'(b_rdata_en), 32'd0);
    @(negedge clk);
    ssram_rdata_en = 1'b0;
    #1;
    chk("ab_b_ready_after", 32'(b_ready), 32'd1);
    chk("ab_a_rdata_held", 32'(a_rdata), 32'h5C);
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    chk("ab_b_issue_addr", 32'(ssram_address), 32'h12345);
    chk("ab_b_issue_write", 32'(ssram_write), 32'd0);
    @(negedge clk);
    ssram_rdata_en = 1'b1; ssram_rdata = 8'hAB;
    #1;
    chk("ab_b_rdata_en", 32'(b_rdata_en), 32'd1);
    chk("ab_b_rdata", 32'(b_rdata), 32'hAB);
    chk("ab_a_rdata_en_quiet", 32'(a_rdata_en), 32'd0);
    @(negedge clk);
    ssram_rdata_en = 1'b0;
    #1;
    chk("ab_b_rdata_en_one_cycle", 32'(b_rdata_en), 32'd0);

    // ---------------- reset during a pending read ----------------
    @(negedge clk);
    b_valid = 1'b1; b_write = 1'b0; b_address = 19'h0ABCD;
    #1;
    chk("rm_b_ready", 32'(b_ready), 32'd1);
    @(negedge clk);
    b_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rm_valid_cleared", 32'(ssram_valid), 32'd0);
    chk("rm_no_strobe_in_reset", 32'({a_rdata_en, b_rdata_en}), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ssram_rdata_en = 1'b1; ssram_rdata = 8'h77;
      #1;
      chk("rm_late_data_ignored", 32'({a_rdata_en, b_rdata_en, timeout_error}), 32'd0);
    end
    @(negedge clk);
    ssram_rdata_en = 1'b0;
    a_valid = 1'b1; a_write = 1'b1; a_address = 19'h00123; a_wdata = 8'h12;
    #1;
    chk("rm_a_ready", 32'(a_ready), 32'd1);
    chk("rm_b_ready", 32'(b_ready), 32'd0);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    chk("wr_valid", 32'(ssram_valid), 32'd1);
    chk("wr_address", 32'(ssram_address), 32'h00123);
    chk("wr_wdata", 32'(ssram_wdata), 32'h12);
    chk("wr_write", 32'(ssram_write), 32'd1);
    @(negedge clk);
    #1;
    chk("wr_done", 32'(ssram_valid), 32'd0);

    // ---------------- randomized traffic vs reference ----------------
    do_reset();
    ph = 0; w = 0; resp = -1; m_last = 1'b1; m_owner = 1'b0; m_wr = 1'b0;
    m_addr = 19'd0; m_wd = 8'd0; resp_data = 8'd0;
    a_last = 8'd0; b_last = 8'd0; a_taken = 1'b0; b_taken = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (a_taken) begin a_valid = 1'b0; a_taken = 1'b0; end
      if (b_taken) begin b_valid = 1'b0; b_taken = 1'b0; end
      if (!a_valid && $urandom_range(0, 2) == 0) begin
        a_valid = 1'b1; a_write = 1'($urandom_range(0, 1));
        a_address = 19'($urandom); a_wdata = 8'($urandom);
      end
      if (!b_valid && $urandom_range(0, 2) == 0) begin
        b_valid = 1'b1; b_write = 1'($urandom_range(0, 1));
        b_address = 19'($urandom); b_wdata = 8'($urandom);
      end
      ssram_ready = 1'($urandom_range(0, 1));
      ssram_rdata_en = 1'b0;
      if (resp == 0) begin
        ssram_rdata_en = 1'b1; ssram_rdata = resp_data;
      end else if (ph != 2 && $urandom_range(0, 7) == 0) begin
        ssram_rdata_en = 1'b1; ssram_rdata = 8'($urandom);
      end
      if (resp >= 0) resp--;
      #1;
      // grant expectation
      g_any = (ph == 0) && (a_valid || b_valid);
      g_b   = (a_valid && b_valid) ? ~m_last : b_valid;
      chk("rnd_a_ready", 32'(a_ready), 32'(g_any && !g_b));
      chk("rnd_b_ready", 32'(b_ready), 32'(g_any && g_b));
      chk("rnd_ssram_valid", 32'(ssram_valid), 32'(ph == 1));
      if (ph == 1) begin
        chk("rnd_ssram_address", 32'(ssram_address), 32'(m_addr));
        chk("rnd_ssram_write", 32'(ssram_write), 32'(m_wr));
        if (m_wr) chk("rnd_ssram_wdata", 32'(ssram_wdata), 32'(m_wd));
      end
      // read-return expectation
      e_a_en = 1'b0; e_b_en = 1'b0; e_err = 1'b0; e_val = 8'hFF;
      if (ph == 2) begin
        if (ssram_rdata_en) e_val = ssram_rdata;
        else if (w == TB_TIMEOUT - 1) e_err = 1'b1;
        if (ssram_rdata_en || w == TB_TIMEOUT - 1) begin
          if (m_owner) e_b_en = 1'b1; else e_a_en = 1'b1;
        end
      end
      if (e_a_en) a_last = e_val;
      if (e_b_en) b_last = e_val;
      chk("rnd_a_rdata_en", 32'(a_rdata_en), 32'(e_a_en));
      chk("rnd_b_rdata_en", 32'(b_rdata_en), 32'(e_b_en));
      chk("rnd_timeout_error", 32'(timeout_error), 32'(e_err));
      chk("rnd_a_rdata", 32'(a_rdata), 32'(a_last));
      chk("rnd_b_rdata", 32'(b_rdata), 32'(b_last));
      // advance the reference across the coming edge
      if (ph == 2) begin
        if (e_a_en || e_b_en) ph = 0; else w++;
      end else if (ph == 1) begin
        if (ssram_ready) begin
          if (m_wr) begin
            mem[int'(m_addr)] = m_wd;
            ph = 0;
          end else begin
            ph = 2; w = 0;
            lat = $urandom_range(0, 9);
            if (lat < 6) resp = $urandom_range(0, 5);
            else if (lat < 8) resp = $urandom_range(TB_TIMEOUT - 3, TB_TIMEOUT + 1);
            else resp = -1;
            resp_data = mem.exists(int'(m_addr)) ? mem[int'(m_addr)] : (m_addr[7:0] ^ 8'h5A);
          end
        end
      end else if (g_any) begin
        ph = 1; m_owner = g_b; m_last = g_b;
        m_addr = g_b ? b_address : a_address;
        m_wd   = g_b ? b_wdata   : a_wdata;
        m_wr   = g_b ? b_write   : a_write;
        if (g_b) b_taken = 1'b1; else a_taken = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
